// File: rtl/poly_operand_feeder_if.sv
// ============================================================================
// Module   : poly_operand_feeder_if
// Purpose  : Host write side and evaluator handshake bundle for the feeder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface poly_operand_feeder_if #(
    parameter int ADDR_W = 3
);
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              wr_full;
    logic [ADDR_W:0]   fifo_count;
    logic              overflow;
    logic [7:0]        data_out;
    logic              go;
    logic [7:0]        result_in;
    logic [7:0]        result_out;
    logic              result_valid;
    logic              busy;

    // master: host plus evaluator environment; slave: the feeder itself
    modport master (
        output wr_en, wr_data, result_in,
        input  wr_full, fifo_count, overflow, data_out, go,
               result_out, result_valid, busy
    );

    modport slave (
        input  wr_en, wr_data, result_in,
        output wr_full, fifo_count, overflow, data_out, go,
               result_out, result_valid, busy
    );
endinterface

`default_nettype wire

// File: rtl/poly_operand_feeder.sv
// ============================================================================
// Module   : poly_operand_feeder
// Purpose  : Buffers A,B,C,X operand bytes and replays the evaluator's go
//            press/release handshake per word, then captures the result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module poly_operand_feeder #(
    parameter int DEPTH        = 8,
    parameter int ADDR_W       = 3,
    parameter int GO_HIGH      = 2,
    parameter int GO_LOW       = 2,
    parameter int COMPUTE_WAIT = 6
) (
    input  logic                  clk,
    input  logic                  resetn,
    poly_operand_feeder_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_PRESS   = 3'd2,
        S_RELEASE = 3'd3,
        S_COMPUTE = 3'd4,
        S_CAPTURE = 3'd5
    } state_t;

    localparam logic [ADDR_W:0] C_DEPTH        = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] C_SET_BYTES    = (ADDR_W+1)'(4);
    localparam logic [7:0]      C_HIGH_LAST    = 8'(GO_HIGH - 1);
    localparam logic [7:0]      C_LOW_LAST     = 8'(GO_LOW - 1);
    localparam logic [7:0]      C_COMPUTE_LAST = 8'(COMPUTE_WAIT - 1);

    state_t              state_q, state_d;
    logic [7:0]          timer_q, timer_d;
    logic [1:0]          word_idx_q, word_idx_d;
    logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]     count_q;
    logic [7:0]          mem_q [DEPTH];
    logic                overflow_q;
    logic [7:0]          data_out_q;
    logic                go_q;
    logic [7:0]          result_q;
    logic                valid_q;

    logic                w_full;
    logic                w_wr_accept;
    logic                w_pop;
    logic                w_capture;

    assign w_full      = (count_q == C_DEPTH);
    assign w_wr_accept = bus.wr_en && !w_full;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        word_idx_d = word_idx_q;
        w_pop      = 1'b0;
        w_capture  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q >= C_SET_BYTES) begin
                    w_pop      = 1'b1;
                    word_idx_d = 2'd0;
                    timer_d    = 8'd0;
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                timer_d = 8'd0;
                state_d = S_PRESS;
            end
            S_PRESS: begin
                if (timer_q == C_HIGH_LAST) begin
                    timer_d = 8'd0;
                    state_d = S_RELEASE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_RELEASE: begin
                if (timer_q == C_LOW_LAST) begin
                    timer_d = 8'd0;
                    if (word_idx_q != 2'd3) begin
                        w_pop      = 1'b1;
                        word_idx_d = word_idx_q + 2'd1;
                        state_d    = S_SETUP;
                    end else begin
                        state_d = S_COMPUTE;
                    end
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_COMPUTE: begin
                if (timer_q == C_COMPUTE_LAST) begin
                    timer_d = 8'd0;
                    state_d = S_CAPTURE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_CAPTURE: begin
                w_capture = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                timer_d = 8'd0;
            end
        endcase
    end

    // Storage carries no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            timer_q    <= 8'd0;
            word_idx_q <= 2'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            data_out_q <= 8'd0;
            go_q       <= 1'b0;
            result_q   <= 8'd0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            word_idx_q <= word_idx_d;
            if (w_wr_accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                data_out_q <= mem_q[rd_ptr_q];
            end
            case ({w_wr_accept, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (bus.wr_en && w_full) begin
                overflow_q <= 1'b1;
            end
            go_q    <= (state_d == S_PRESS);
            valid_q <= w_capture;
            if (w_capture) begin
                result_q <= bus.result_in;
            end
        end
    end

    assign bus.wr_full      = w_full;
    assign bus.fifo_count   = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.data_out     = data_out_q;
    assign bus.go           = go_q;
    assign bus.result_out   = result_q;
    assign bus.result_valid = valid_q;
    assign bus.busy         = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_poly_operand_feeder.sv
// ============================================================================
// Module   : tb_poly_operand_feeder
// Purpose  : Directed bench for the operand feeder with a behavioural evaluator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_poly_operand_feeder;

    logic clk = 1'b0;
    logic resetn;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    poly_operand_feeder_if #(.ADDR_W(3)) intf ();

    poly_operand_feeder #(
        .DEPTH        (8),
        .ADDR_W       (3),
        .GO_HIGH      (2),
        .GO_LOW       (2),
        .COMPUTE_WAIT (6)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (intf)
    );

    // Evaluator stand-in: latches a word on each go rise, computes after the X release.
    logic [7:0] ev_w [4];
    int         ev_idx;
    int         ev_cnt;
    logic       ev_go_q;
    logic [7:0] ev_result;

    always @(posedge clk) begin
        if (!resetn) begin
            ev_idx    <= 0;
            ev_cnt    <= 0;
            ev_go_q   <= 1'b0;
            ev_result <= 8'd0;
        end else begin
            ev_go_q <= intf.go;
            if (intf.go && !ev_go_q && ev_idx < 4) begin
                ev_w[ev_idx] <= intf.data_out;
                ev_idx       <= ev_idx + 1;
            end
            if (!intf.go && ev_go_q && ev_idx == 4) begin
                ev_cnt <= 6;
            end
            if (ev_cnt == 1) begin
                ev_result <= 8'(int'(ev_w[0]) * int'(ev_w[3]) * int'(ev_w[3])
                              + int'(ev_w[1]) * int'(ev_w[3]) + int'(ev_w[2]));
                ev_idx    <= 0;
            end
            if (ev_cnt > 0) begin
                ev_cnt <= ev_cnt - 1;
            end
        end
    end

    assign intf.result_in = ev_result;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] b);
        intf.wr_en   = 1'b1;
        intf.wr_data = b;
        @(negedge clk);
        intf.wr_en   = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int cyc);
        cyc = 0;
        while (!intf.result_valid && cyc < limit) begin
            tick(1);
            cyc++;
        end
        check("result_valid_seen", {31'd0, intf.result_valid}, 32'd1);
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_go"},       {31'd0, intf.go},           32'd0);
        check({tag, "_data_out"}, {24'd0, intf.data_out},     32'd0);
        check({tag, "_result"},   {24'd0, intf.result_out},   32'd0);
        check({tag, "_valid"},    {31'd0, intf.result_valid}, 32'd0);
        check({tag, "_overflow"}, {31'd0, intf.overflow},     32'd0);
        check({tag, "_count"},    {28'd0, intf.fifo_count},   32'd0);
        check({tag, "_busy"},     {31'd0, intf.busy},         32'd0);
    endtask

    initial begin
        int cyc;
        int gap;
        int pulses;
        logic exp_go;
        logic [7:0] exp_data;

        resetn       = 1'b0;
        intf.wr_en   = 1'b0;
        intf.wr_data = 8'd0;
        tick(2);
        check_idle_reset("reset");
        resetn = 1'b1;

        // Nominal set with cycle-by-cycle handshake trace
        wr(8'd1); wr(8'd2); wr(8'd3); wr(8'd4);
        check("nom_count_loaded", {28'd0, intf.fifo_count}, 32'd4);
        check("nom_busy_before",  {31'd0, intf.busy},       32'd0);
        pulses = 0;
        for (int n = 1; n <= 27; n++) begin
            tick(1);
            if (n <= 20) begin
                exp_go   = ((n - 1) % 5 == 1) || ((n - 1) % 5 == 2);
                exp_data = 8'((n - 1) / 5 + 1);
            end else begin
                exp_go   = 1'b0;
                exp_data = 8'd4;
            end
            check($sformatf("nom_go_c%0d", n),   {31'd0, intf.go},       {31'd0, exp_go});
            check($sformatf("nom_data_c%0d", n), {24'd0, intf.data_out}, {24'd0, exp_data});
            check($sformatf("nom_busy_c%0d", n), {31'd0, intf.busy},     32'd1);
            if (intf.result_valid) pulses++;
        end
        check("nom_no_early_valid", pulses, 0);
        tick(1);
        check("nom_valid",      {31'd0, intf.result_valid}, 32'd1);
        check("nom_result",     {24'd0, intf.result_out},   32'h1B);
        check("nom_busy_after", {31'd0, intf.busy},         32'd0);
        check("nom_count_after",{28'd0, intf.fifo_count},   32'd0);
        tick(1);
        check("nom_valid_one_cycle", {31'd0, intf.result_valid}, 32'd0);

        // Partial set: three bytes must not start a sequence
        wr(8'd1); wr(8'd1); wr(8'd1);
        tick(3);
        check("part_busy",  {31'd0, intf.busy},       32'd0);
        check("part_go",    {31'd0, intf.go},         32'd0);
        check("part_count", {28'd0, intf.fifo_count}, 32'd3);
        wr(8'd2);
        check("part_still_idle", {31'd0, intf.busy}, 32'd0);
        tick(1);
        check("part_setup_busy", {31'd0, intf.busy},     32'd1);
        check("part_setup_go",   {31'd0, intf.go},       32'd0);
        check("part_setup_data", {24'd0, intf.data_out}, 32'd1);
        wait_valid(40, cyc);
        check("part_result", {24'd0, intf.result_out}, 32'd7);

        // Mod-256 wrap and back-to-back sets, pointers pass DEPTH
        wr(8'd16); wr(8'd0); wr(8'd5); wr(8'd4);
        wr(8'd2);  wr(8'd3); wr(8'd1); wr(8'd5);
        wait_valid(60, cyc);
        check("wrap_result", {24'd0, intf.result_out}, 32'h05);
        tick(1);
        wait_valid(40, gap);
        check("b2b_gap",      gap + 1, 28);
        check("b2b_result",   {24'd0, intf.result_out}, 32'h42);
        check("b2b_count",    {28'd0, intf.fifo_count}, 32'd0);
        check("b2b_busy",     {31'd0, intf.busy},       32'd0);

        // Full / overflow; 5th write coincides with the first pop
        wr(8'd1); wr(8'd2); wr(8'd3); wr(8'd4); wr(8'd9);
        check("wrpop_count",    {28'd0, intf.fifo_count}, 32'd4);
        check("wrpop_overflow", {31'd0, intf.overflow},   32'd0);
        tick(16);
        check("compute_count",  {28'd0, intf.fifo_count}, 32'd1);
        for (int i = 0; i < 7; i++) wr(8'(10 + i));
        check("full_flag",      {31'd0, intf.wr_full},    32'd1);
        check("full_count",     {28'd0, intf.fifo_count}, 32'd8);
        check("full_no_ovf",    {31'd0, intf.overflow},   32'd0);
        wr(8'd99);
        check("ovf_count",      {28'd0, intf.fifo_count}, 32'd8);
        check("ovf_full",       {31'd0, intf.wr_full},    32'd1);
        check("ovf_set",        {31'd0, intf.overflow},   32'd1);
        wait_valid(10, cyc);
        check("ovf_set_result", {24'd0, intf.result_out}, 32'h1B);
        check("ovf_sticky",     {31'd0, intf.overflow},   32'd1);

        resetn = 1'b0;
        tick(1);
        check_idle_reset("reset2");
        resetn = 1'b1;

        // Reset during the PRESS of word C
        wr(8'd1); wr(8'd2); wr(8'd3); wr(8'd4);
        tick(12);
        check("midC_go",   {31'd0, intf.go},       32'd1);
        check("midC_data", {24'd0, intf.data_out}, 32'd3);
        resetn = 1'b0;
        tick(1);
        check("midC_rst_go",    {31'd0, intf.go},         32'd0);
        check("midC_rst_count", {28'd0, intf.fifo_count}, 32'd0);
        check("midC_rst_busy",  {31'd0, intf.busy},       32'd0);
        resetn = 1'b1;
        wr(8'd1); wr(8'd2); wr(8'd3); wr(8'd4);
        wait_valid(40, cyc);
        check("midC_fresh_result", {24'd0, intf.result_out}, 32'h1B);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/poly_operand_feeder.md
Name: poly_operand_feeder

Overview:
- Upstream sequencer for the polynomial evaluator, which computes A*X^2 + B*X + C mod 256.
- Buffers operand bytes written by a host (test harness, UART or switch logic) in a small FIFO.
- Once a full A,B,C,X set is buffered, replays the evaluator's manual go press/release handshake for each word.
- Waits for the evaluator's fixed compute window, then captures the evaluator's result and flags it valid for one cycle.

Parameters:
- DEPTH, 8: FIFO depth in bytes; power of 2, at least 4.
- ADDR_W, 3: log2(DEPTH).
- GO_HIGH, 2: number of cycles go is held high per word; at least 1.
- GO_LOW, 2: number of cycles go is held low after each press; at least 1.
- COMPUTE_WAIT, 6: cycles spent in COMPUTE after the X release; GO_LOW + COMPUTE_WAIT must be at least 7.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- wr_en  in  1  host write strobe.
- wr_data  in  8  operand byte; write order is A,B,C,X, repeating.
- wr_full  out  1  high when count == DEPTH.
- fifo_count  out  ADDR_W+1  bytes currently buffered.
- overflow  out  1  sticky; set by a write while full.
- data_out  out  8  operand byte driven to the evaluator's data_in.
- go  out  1  press signal to the evaluator, active high.
- result_in  in  8  evaluator's data_result.
- result_out  out  8  captured result.
- result_valid  out  1  one-cycle pulse when result_out updates.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs are 0 on the clk edge with resetn low (data_out, go, result_out, result_valid, overflow, fifo_count, busy). FIFO pointers and count clear, FSM goes to IDLE, the word index and timer clear. Reset mid-sequence aborts immediately; the evaluator shares resetn, so both restart in their load-A position.
- FIFO write side: a write is accepted in any FSM state when count < DEPTH. A write while full is dropped, count is unchanged, and overflow sets. Pointers wrap modulo DEPTH.
- FIFO pop side: pops occur only on the FSM transitions marked "pop" below. A simultaneous accepted write and pop leaves count unchanged.
- go is a registered output, high only in PRESS. data_out is registered, loaded only at a pop, and held stable until the next pop.
- FSM states and transitions:
  - IDLE: when count >= 4, pop the head into data_out, set word_idx=0, go to SETUP. Otherwise stay.
  - SETUP: 1 cycle with go=0 and data_out stable, so the evaluator samples a settled value. Then go to PRESS.
  - PRESS: GO_HIGH cycles with go=1. Then go to RELEASE.
  - RELEASE: GO_LOW cycles with go=0. Then:
    - if word_idx < 3: pop the next byte, increment word_idx, go to SETUP;
    - else: go to COMPUTE.
  - COMPUTE: COMPUTE_WAIT cycles with go=0. Then go to CAPTURE.
  - CAPTURE: 1 cycle; result_out <= result_in, result_valid=1. Then go to IDLE.
- Word pops therefore never underflow: 4 bytes are guaranteed at the start of a set, and writes can only add bytes.
- Evaluator timing basis: the evaluator leaves its X-wait state one cycle after it sees go=0. It then runs 5 compute cycles, and its result register updates at the end of the 5th. With the defaults, the result is stable from COMPUTE cycle 5, and capture occurs after cycle 6.
- Back-to-back sets: returning to IDLE with count >= 4 starts the next set on the following cycle. The minimum cycles per set is 4*(1+GO_HIGH+GO_LOW) + COMPUTE_WAIT + 2, which is 28 with the defaults.
- The feeder performs no arithmetic; the mod-256 wrap is the evaluator's behaviour and is only passed through.

Test Plan:
- Nominal set: write 1,2,3,4 and connect the real evaluator -> after a 28-cycle sequence, exactly one result_valid pulse with result_out=0x1B (27); then busy=0 and fifo_count=0.
- Handshake timing: check go and data_out cycle by cycle -> each byte is stable 1 cycle before go rises; go is high exactly 2 cycles and low at least 2 cycles; bytes appear in the order 1,2,3,4.
- Partial set: write 3 bytes -> stays IDLE with go=0. Write a 4th byte -> SETUP on the next cycle.
- Wrap-around and back-to-back: write 16,0,5,4 then 2,3,1,5 -> result_out 0x05 (256+5 wraps), then 0x42 (50+15+1=66). Consecutive sets are separated only by the IDLE cycle, and pointers wrap past DEPTH.
- Full/overflow: with the FIFO idle and full (8 bytes), write once more and pop while writing -> wr_full=1, overflow latches 1, count stays 8 on the dropped write. On a concurrent write and pop, count is unchanged and no overflow is added.
- Reset mid-PRESS of word C: assert resetn low for 1 cycle -> go=0, fifo_count=0, IDLE. A fresh 1,2,3,4 afterwards yields 0x1B.
